// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - multi-cycle multiply/divide sequencer owning HI/LO
// Optional madd/maddu/msub/msubu accumulate ops are enabled by defining MDU_MADD_EN.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] pend_hi, pend_lo;
  logic        is_mul, is_div, is_long, mul_signed;
  logic [63:0] opa, opb, prod, res;
  logic [31:0] quo, rem;

  always_comb begin
    is_mul     = (md_op == OP_MULT) || (md_op == OP_MULTU);
    mul_signed = (md_op == OP_MULT);
`ifdef MDU_MADD_EN
    is_mul     = is_mul || (md_op == OP_MADD) || (md_op == OP_MADDU) ||
                 (md_op == OP_MSUB) || (md_op == OP_MSUBU);
    mul_signed = mul_signed || (md_op == OP_MADD) || (md_op == OP_MSUB);
`endif
    is_div     = (md_op == OP_DIV) || (md_op == OP_DIVU);
  end

  assign is_long   = start & (is_mul | is_div);
  assign busy      = (state == RUN);
  assign stall_req = busy | is_long;

  // Low 64 bits of a 64x64 product of extended operands equal the 32x32 result
  always_comb begin
    opa  = mul_signed ? {{32{a[31]}}, a} : {32'h0, a};
    opb  = mul_signed ? {{32{b[31]}}, b} : {32'h0, b};
    prod = opa * opb;
  end

  always_comb begin
    quo = 32'hFFFF_FFFF;
    rem = a;
    if (b != 32'h0) begin
      if (md_op == OP_DIV) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          quo = 32'h8000_0000;
          rem = 32'h0;
        end else begin
          quo = $signed(a) / $signed(b);
          rem = $signed(a) % $signed(b);
        end
      end else begin
        quo = a / b;
        rem = a % b;
      end
    end
  end

  always_comb begin
    res = prod;
    if (is_div) begin
      res = {rem, quo};
    end
`ifdef MDU_MADD_EN
    else if (md_op == OP_MADD || md_op == OP_MADDU) begin
      res = {hi, lo} + prod;
    end else if (md_op == OP_MSUB || md_op == OP_MSUBU) begin
      res = {hi, lo} - prod;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_long) state_nxt = RUN;
      RUN:     if (cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Starts that arrive while RUN are dropped; the hazard unit holds them in D
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      hi      <= 32'h0;
      lo      <= 32'h0;
    end else if (state == IDLE) begin
      if (is_long) begin
        {pend_hi, pend_lo} <= res;
        cnt <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (start && md_op == OP_MTHI) begin
        hi <= a;
      end else if (start && md_op == OP_MTLO) begin
        lo <= a;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb/tb_md_unit_ctrl.sv - self-checking bench for md_unit_ctrl
module tb_md_unit_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  md_unit_ctrl #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural HI/LO, result waiting to land, cycles remaining
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
  logic [63:0] m_pend = 64'h0;
  int          m_left = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] av, bv, ehi, elo;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit madd_en();
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit op_mul(input logic [3:0] op);
    return op == 4'd1 || op == 4'd2 || (madd_en() && op >= 4'd7 && op <= 4'd10);
  endfunction

  function automatic bit op_div(input logic [3:0] op);
    return op == 4'd3 || op == 4'd4;
  endfunction

  function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] av, bv,
                                           input logic [31:0] h, l);
    longint sa, sb, q, r;
    longint unsigned ua, ub, acc;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ua  = {32'h0, av};
    ub  = {32'h0, bv};
    acc = {h, l};
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (bv == 32'h0) return {av, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (bv == 32'h0) return {av, 32'hFFFF_FFFF};
        acc = ua / ub;
        ub  = ua % ub;
        return {ub[31:0], acc[31:0]};
      end
      4'd7:    return acc + sa * sb;
      4'd8:    return acc + ua * ub;
      4'd9:    return acc - sa * sb;
      4'd10:   return acc - ua * ub;
      default: return acc;
    endcase
  endfunction

  task automatic model_edge(input logic s, input logic [3:0] op, input logic [31:0] av, bv);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (s) begin
      if (op_mul(op) || op_div(op)) begin
        m_pend = ref_calc(op, av, bv, m_hi, m_lo);
        m_left = op_div(op) ? DIV_LAT : MULT_LAT;
      end else if (op == 4'd5) begin
        m_hi = av;
      end else if (op == 4'd6) begin
        m_lo = av;
      end
    end
  endtask

  task automatic step(input logic s, input logic [3:0] op, input logic [31:0] av, bv);
    start = s; md_op = op; a = av; b = bv;
    #1;
    chk("stall_req", {63'h0, stall_req}, {63'h0, (m_left > 0) || (s && (op_mul(op) || op_div(op)))});
    @(posedge clk);
    model_edge(s, op, av, bv);
    #1;
    chk("busy", {63'h0, busy}, {63'h0, m_left > 0});
    chk("hi", {32'h0, hi}, {32'h0, m_hi});
    chk("lo", {32'h0, lo}, {32'h0, m_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] sv_hi, sv_lo;
    vt[0] = '{4'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[1] = '{4'd2, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vt[2] = '{4'd3, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{4'd3, 32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
    vt[4] = '{4'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[5] = '{4'd4, 32'hFFFF_FFFF,  32'd10,        32'h0000_0005, 32'h1999_9999};
    vt[6] = '{4'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[7] = '{4'd4, 32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
    vt[8] = '{4'd3, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vt[9] = '{4'd2, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_stall", {63'h0, stall_req}, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(1'b1, vt[i].op, vt[i].av, vt[i].bv);
      repeat (op_div(vt[i].op) ? DIV_LAT : MULT_LAT) step(1'b0, 4'd0, 32'h0, 32'h0);
      chk($sformatf("vec%0d_hi", i), {32'h0, hi}, {32'h0, vt[i].ehi});
      chk($sformatf("vec%0d_lo", i), {32'h0, lo}, {32'h0, vt[i].elo});
    end

    // mthi issued mid-divu must be dropped
    step(1'b1, 4'd4, 32'd100, 32'd7);
    step(1'b0, 4'd0, 32'h0, 32'h0);
    step(1'b0, 4'd0, 32'h0, 32'h0);
    step(1'b1, 4'd5, 32'd1234, 32'h0);
    repeat (DIV_LAT - 3) step(1'b0, 4'd0, 32'h0, 32'h0);
    chk("divu_mthi_hi", {32'h0, hi}, 64'd2);
    chk("divu_mthi_lo", {32'h0, lo}, 64'd14);

    // asynchronous reset in the middle of a div
    step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    repeat (3) step(1'b0, 4'd0, 32'h0, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_hi", {32'h0, hi}, 64'h0);
    chk("arst_lo", {32'h0, lo}, 64'h0);
    m_hi = 32'h0; m_lo = 32'h0; m_left = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (DIV_LAT + 2) step(1'b0, 4'd0, 32'h0, 32'h0);
    chk("arst_nocommit_lo", {32'h0, lo}, 64'h0);

`ifdef MDU_MADD_EN
    step(1'b1, 4'd6, 32'd10, 32'h0);
    step(1'b1, 4'd5, 32'd0, 32'h0);
    step(1'b1, 4'd7, 32'd3, 32'd4);
    repeat (MULT_LAT) step(1'b0, 4'd0, 32'h0, 32'h0);
    chk("madd_hi", {32'h0, hi}, 64'd0);
    chk("madd_lo", {32'h0, lo}, 64'd22);
`else
    step(1'b1, 4'd6, 32'd10, 32'h0);
    sv_hi = m_hi; sv_lo = m_lo;
    start = 1'b1; md_op = 4'd7; a = 32'd3; b = 32'd4;
    #1;
    chk("op7_stall", {63'h0, stall_req}, 64'h0);
    step(1'b1, 4'd7, 32'd3, 32'd4);
    chk("op7_busy", {63'h0, busy}, 64'h0);
    chk("op7_lo", {32'h0, lo}, {32'h0, sv_lo});
    chk("op7_hi", {32'h0, hi}, {32'h0, sv_hi});
`endif

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), pick(), pick());
    end
    repeat (DIV_LAT + 1) step(1'b0, 4'd0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
